// File: rtl/median_frame_ctrl_if.sv
// ----------------------------------------------------------------------------
// median_frame_ctrl_if
//
// Bundles the three data paths the frame controller touches:
//   - source pixel memory read port   (src_rd_en, src_addr, src_rd_data)
//   - 3x3 median filter stream ports  (filt_valid, filt_data,
//                                      filt_valid_out, filt_data_out)
//   - destination memory write port   (dst_wr_en, dst_addr, dst_wr_data)
//
// Modports:
//   master - the frame controller (drives read strobe/address, filter input,
//            destination write; receives read data and filter output)
//   slave  - the memories/filter side of the same connections
// ----------------------------------------------------------------------------
interface median_frame_ctrl_if #(
    parameter int PIXEL_WIDTH = 8,
    parameter int ADDR_WIDTH  = 6
);

    logic                   src_rd_en;
    logic [ADDR_WIDTH-1:0]  src_addr;
    logic [PIXEL_WIDTH-1:0] src_rd_data;

    logic                   filt_valid;
    logic [PIXEL_WIDTH-1:0] filt_data;
    logic                   filt_valid_out;
    logic [PIXEL_WIDTH-1:0] filt_data_out;

    logic                   dst_wr_en;
    logic [ADDR_WIDTH-1:0]  dst_addr;
    logic [PIXEL_WIDTH-1:0] dst_wr_data;

    modport master (
        output src_rd_en,
        output src_addr,
        input  src_rd_data,
        output filt_valid,
        output filt_data,
        input  filt_valid_out,
        input  filt_data_out,
        output dst_wr_en,
        output dst_addr,
        output dst_wr_data
    );

    modport slave (
        input  src_rd_en,
        input  src_addr,
        output src_rd_data,
        input  filt_valid,
        input  filt_data,
        output filt_valid_out,
        output filt_data_out,
        input  dst_wr_en,
        input  dst_addr,
        input  dst_wr_data
    );

endinterface

// File: rtl/median_frame_ctrl.sv
// ----------------------------------------------------------------------------
// median_frame_ctrl
//
// Frame sequencer for the 3x3 median filter. A start pulse in IDLE reads one
// IMAGE_WIDTH x IMAGE_HEIGHT frame from the source memory in raster order and
// streams it into the filter; every filtered pixel that comes back is written
// to the destination memory at consecutive addresses. The drain phase is
// guarded by a watchdog so a silent filter cannot hang the controller.
//
// Ports:
//   clk, rst_n        clock and asynchronous active-low reset
//   start             one-cycle frame request (only honoured in IDLE)
//   hold              pauses source reads while high (ISSUE only)
//   busy              high while issuing or draining
//   done              one-cycle completion pulse
//   err               sticky: watchdog expiry or excess filter output;
//                     cleared by an accepted start
//   out_count         filtered pixels captured in the current frame
//   bus (master)      source read port, filter stream ports, destination
//                     write port (see median_frame_ctrl_if)
// ----------------------------------------------------------------------------
module median_frame_ctrl #(
    parameter int IMAGE_WIDTH  = 8,
    parameter int IMAGE_HEIGHT = 8,
    parameter int WINDOW_SIZE  = 3,
    parameter int PIXEL_WIDTH  = 8,
    parameter int ADDR_WIDTH   = 6,
    parameter int TIMEOUT      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  hold,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_WIDTH-1:0] out_count,
    median_frame_ctrl_if.master   bus
);

    localparam int N     = IMAGE_WIDTH * IMAGE_HEIGHT;
    localparam int EXP   = (IMAGE_WIDTH - WINDOW_SIZE + 1) * (IMAGE_HEIGHT - WINDOW_SIZE + 1);
    localparam int PTR_W = $clog2(N + 1);
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    localparam logic [PTR_W-1:0]      PTR_END   = PTR_W'(N);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(N - 1);
    localparam logic [ADDR_WIDTH-1:0] EXP_CNT   = ADDR_WIDTH'(EXP);
    localparam logic [TMR_W-1:0]      TMR_LAST  = TMR_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t state;
    state_t next_state;

    // Internal counters
    logic [PTR_W-1:0]       rd_ptr,       rd_ptr_d;
    logic [TMR_W-1:0]       timer,        timer_d;

    // Registered outputs and their next values
    logic                   rd_en_q,      rd_en_d;
    logic [ADDR_WIDTH-1:0]  src_addr_q,   src_addr_d;
    logic                   filt_valid_q;
    logic                   wr_en_q,      wr_en_d;
    logic [ADDR_WIDTH-1:0]  dst_addr_q,   dst_addr_d;
    logic [PIXEL_WIDTH-1:0] wr_data_q,    wr_data_d;
    logic                   busy_q,       busy_d;
    logic                   done_q,       done_d;
    logic                   err_q,        err_d;
    logic [ADDR_WIDTH-1:0]  out_count_q,  out_count_d;

    // Status decodes
    logic last_issued;
    logic capture_window;
    logic accept_pixel;
    logic excess_pixel;
    logic drain_ok;
    logic drain_expired;

    // The read for address N-1 is visible on the registered strobe during
    // the final ISSUE cycle; that is the moment to move on to DRAIN.
    assign last_issued    = rd_en_q && (src_addr_q == LAST_ADDR);
    assign capture_window = (state == ST_ISSUE) || (state == ST_DRAIN);
    assign accept_pixel   = capture_window && bus.filt_valid_out && (out_count_q < EXP_CNT);
    assign excess_pixel   = capture_window && bus.filt_valid_out && (out_count_q >= EXP_CNT);
    assign drain_ok       = (out_count_q == EXP_CNT);
    assign drain_expired  = (timer == TMR_LAST);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. A full frame is always issued once started, because
    // the filter's row/column tracking relies on complete frames.
    always_comb begin
        next_state = state;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    next_state = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (last_issued) begin
                    next_state = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (drain_ok || drain_expired) begin
                    next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Output logic: computes the next value of every registered output and
    // counter. All outputs are registered, so the read for address 0 is
    // launched on the same edge that accepts start; rd_ptr therefore lands
    // on 1 rather than 0 at that edge.
    always_comb begin
        rd_ptr_d    = rd_ptr;
        timer_d     = timer;
        rd_en_d     = 1'b0;
        src_addr_d  = src_addr_q;
        wr_en_d     = 1'b0;
        dst_addr_d  = dst_addr_q;
        wr_data_d   = wr_data_q;
        err_d       = err_q;
        out_count_d = out_count_q;

        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    rd_en_d     = 1'b1;
                    src_addr_d  = '0;
                    rd_ptr_d    = PTR_W'(1);
                    timer_d     = '0;
                    out_count_d = '0;
                    err_d       = 1'b0;
                end
            end
            ST_ISSUE: begin
                if (!last_issued && (rd_ptr < PTR_END) && !hold) begin
                    rd_en_d    = 1'b1;
                    src_addr_d = ADDR_WIDTH'(rd_ptr);
                    rd_ptr_d   = rd_ptr + PTR_W'(1);
                end
            end
            ST_DRAIN: begin
                timer_d = timer + TMR_W'(1);
                // Reaching the expected count on the same cycle as the
                // watchdog counts as success.
                if (!drain_ok && drain_expired) begin
                    err_d = 1'b1;
                end
            end
            default: begin
            end
        endcase

        if (accept_pixel) begin
            wr_en_d     = 1'b1;
            dst_addr_d  = out_count_q;
            wr_data_d   = bus.filt_data_out;
            out_count_d = out_count_q + ADDR_WIDTH'(1);
        end

        // Anything beyond the expected output count is dropped and flagged.
        if (excess_pixel) begin
            err_d = 1'b1;
        end
    end

    assign busy_d = (next_state == ST_ISSUE) || (next_state == ST_DRAIN);
    assign done_d = (next_state == ST_DONE);

    // Output and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr       <= '0;
            timer        <= '0;
            rd_en_q      <= 1'b0;
            src_addr_q   <= '0;
            filt_valid_q <= 1'b0;
            wr_en_q      <= 1'b0;
            dst_addr_q   <= '0;
            wr_data_q    <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            out_count_q  <= '0;
        end else begin
            rd_ptr       <= rd_ptr_d;
            timer        <= timer_d;
            rd_en_q      <= rd_en_d;
            src_addr_q   <= src_addr_d;
            filt_valid_q <= rd_en_q;
            wr_en_q      <= wr_en_d;
            dst_addr_q   <= dst_addr_d;
            wr_data_q    <= wr_data_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            out_count_q  <= out_count_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign out_count = out_count_q;

    assign bus.src_rd_en   = rd_en_q;
    assign bus.src_addr    = src_addr_q;
    assign bus.filt_valid  = filt_valid_q;
    // Read data arrives one cycle after the strobe, exactly when filt_valid
    // is high, so it goes to the filter unregistered.
    assign bus.filt_data   = bus.src_rd_data;
    assign bus.dst_wr_en   = wr_en_q;
    assign bus.dst_addr    = dst_addr_q;
    assign bus.dst_wr_data = wr_data_q;

endmodule

// File: doc/median_frame_ctrl.md
# median_frame_ctrl

Frame-level sequencer for the 3x3 median filter datapath. On a start pulse it reads one IMAGE_WIDTH x IMAGE_HEIGHT frame from a source pixel memory in raster order and streams it into the filter as valid-qualified pixels. It captures every filtered output pixel, writes it to a destination memory at consecutive addresses, and reports completion or timeout. It sits between the frame buffers and the filter, and is the only master of the filter's input port.

## Interface
Parameters:
- IMAGE_WIDTH, 8, frame width in pixels (≥ WINDOW_SIZE)
- IMAGE_HEIGHT, 8, frame height in pixels (≥ WINDOW_SIZE)
- WINDOW_SIZE, 3, filter window edge; must match the filter instance
- PIXEL_WIDTH, 8, pixel bits
- ADDR_WIDTH, 6, memory address bits; 2^ADDR_WIDTH ≥ IMAGE_WIDTH*IMAGE_HEIGHT
- TIMEOUT, 16, drain watchdog in cycles (≥ 1)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to process a frame; honoured only in IDLE
- hold  in  1  pauses source reads while high (ISSUE state only)
- busy  out  1  high in ISSUE and DRAIN
- done  out  1  one-cycle pulse in DONE
- err  out  1  sticky error flag; cleared by an accepted start
- out_count  out  ADDR_WIDTH  filtered pixels captured this frame
- src_rd_en  out  1  source memory read strobe
- src_addr  out  ADDR_WIDTH  source read address
- src_rd_data  in  PIXEL_WIDTH  source read data, valid 1 cycle after src_rd_en
- filt_valid  out  1  to filter data_valid
- filt_data  out  PIXEL_WIDTH  to filter data_in
- filt_valid_out  in  1  from filter data_valid_out
- filt_data_out  in  PIXEL_WIDTH  from filter data_out
- dst_wr_en  out  1  destination write strobe
- dst_addr  out  ADDR_WIDTH  destination write address
- dst_wr_data  out  PIXEL_WIDTH  destination write data

## Operation
- Derived constants: N = IMAGE_WIDTH*IMAGE_HEIGHT; EXP = (IMAGE_WIDTH-WINDOW_SIZE+1)*(IMAGE_HEIGHT-WINDOW_SIZE+1) (36 for the defaults).
- FSM states and transitions:
  - IDLE: start → ISSUE; rd_ptr, out_count and the timer are cleared, and err is cleared.
  - ISSUE: each cycle with hold=0 asserts src_rd_en with src_addr=rd_ptr, then increments rd_ptr. A cycle with hold=1 issues nothing and keeps rd_ptr. Issuing address N-1 → DRAIN.
  - DRAIN: the timer increments every cycle. When out_count==EXP → DONE. Otherwise, when the timer reaches TIMEOUT → DONE and err is set. If both conditions are true in the same cycle, it is a success (err is not set).
  - DONE: done=1 for one cycle → IDLE.
- Filter feed: filt_valid is src_rd_en registered by one cycle. filt_data is wired directly to src_rd_data. Gaps caused by hold appear as filt_valid=0 cycles; the filter tolerates these.
- Output capture in ISSUE or DRAIN: when filt_valid_out=1 and out_count<EXP, the next cycle has dst_wr_en=1, dst_addr=out_count (pre-increment) and dst_wr_data=filt_data_out, and out_count increments.
- Excess output: when filt_valid_out=1 and out_count==EXP, the pixel is dropped (no write) and err is set.
- filt_valid_out in IDLE or DONE is ignored: no write, no error.
- start while not in IDLE is ignored and has no effect.
- The filter's internal row/column state persists across frames; frames must therefore always be issued complete (N pixels). The controller never aborts a frame except on reset.

## Timing
- Reset values: busy=0, done=0, err=0, out_count=0, src_rd_en=0, src_addr=0, filt_valid=0, dst_wr_en=0, dst_addr=0, dst_wr_data=0. State=IDLE.
- start at cycle t → first src_rd_en at t+1, first filt_valid at t+2.
- With hold=0 throughout, reads are issued on cycles t+1 … t+N and DRAIN is entered at t+N+1.
- Write latency: filt_valid_out at cycle c → dst_wr_en at c+1.
- All outputs are registered except filt_data.
- Reset asserted mid-frame forces all outputs to their reset values immediately and returns to IDLE. No partial-frame recovery is required.

## Test plan
- Constant frame, all pixels 50, default parameters, start → 36 writes to dst_addr 0..35, all with data 50; one done pulse; err=0; out_count=36.
- 8x8 frame with value 0 everywhere except pixel address 27 = 255 (impulse) → 36 writes, all 0 (the impulse is removed); err=0.
- Same frame, hold toggled high for 3 cycles every 5 cycles → src_addr covers 0..63 exactly once each; the write sequence is identical to the unheld run.
- Filter replaced by a stub that never asserts filt_valid_out → DRAIN lasts TIMEOUT=16 cycles, then done with err=1 and out_count=0.
- Stub emitting 37 valid outputs → 36 writes; the 37th is dropped; err=1. A following start clears err.
- Assert rst_n=0 after 20 reads, release, then start a fresh frame → outputs are at reset values during reset. Note that the filter's own internal row/column state is not reset by this stimulus and is out of sync after an aborted frame. For the second frame's reference output, the bench applies the same rst_n pulse to the filter instance (both blocks reset together). Under that condition the second frame produces 36 correct writes with err=0. A start pulse given while busy is ignored.
